// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU issue controller: funct codes, ALUOp classes,
// ALU operation codes and the issue FSM state type.
package alu_ctrl_pkg;

    localparam logic [5:0] FN_SRA  = 6'd3;
    localparam logic [5:0] FN_SRAV = 6'd7;
    localparam logic [5:0] FN_JR   = 6'd8;
    localparam logic [5:0] FN_MUL  = 6'd24;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_SLT  = 6'd42;

    localparam logic [2:0] AOP_RTYPE = 3'd0;
    localparam logic [2:0] AOP_C1    = 3'd1;
    localparam logic [2:0] AOP_C2    = 3'd2;
    localparam logic [2:0] AOP_C3    = 3'd3;
    localparam logic [2:0] AOP_C4    = 3'd4;
    localparam logic [2:0] AOP_C5    = 3'd5;
    localparam logic [2:0] AOP_LUI   = 3'd6;
    localparam logic [2:0] AOP_C7    = 3'd7;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_C3   = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_MUL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_C7   = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SRAV = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1011;
    localparam logic [3:0] ALU_C12  = 4'b1100;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational decode of ALUOp/funct into the ALU operation code and
// operand/jump mux selects; flags multiplies and undefined R-type functs.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W = 6,
    parameter int OP_W    = 3,
    parameter int CTRL_W  = 4
) (
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [OP_W-1:0]    alu_op_i,
    output logic [CTRL_W-1:0]  ctrl_o,
    output logic               shamt_sel_o,
    output logic               jump_sel_o,
    output logic               is_mul_o,
    output logic               illegal_o
);

    // Decode table: R-type by funct, every other class by ALUOp alone
    always_comb begin
        ctrl_o      = CTRL_W'(ALU_AND);
        shamt_sel_o = 1'b0;
        jump_sel_o  = 1'b1;
        is_mul_o    = 1'b0;
        illegal_o   = 1'b0;
        if (alu_op_i == OP_W'(AOP_RTYPE)) begin
            case (funct_i)
                FUNCT_W'(FN_SRA): begin
                    ctrl_o      = CTRL_W'(ALU_SRA);
                    shamt_sel_o = 1'b1;
                end
                FUNCT_W'(FN_SRAV): ctrl_o = CTRL_W'(ALU_SRAV);
                FUNCT_W'(FN_MUL): begin
                    ctrl_o   = CTRL_W'(ALU_MUL);
                    is_mul_o = 1'b1;
                end
                FUNCT_W'(FN_ADD):  ctrl_o = CTRL_W'(ALU_ADD);
                FUNCT_W'(FN_SUB):  ctrl_o = CTRL_W'(ALU_SUB);
                FUNCT_W'(FN_AND):  ctrl_o = CTRL_W'(ALU_AND);
                FUNCT_W'(FN_OR):   ctrl_o = CTRL_W'(ALU_OR);
                FUNCT_W'(FN_SLT):  ctrl_o = CTRL_W'(ALU_SLT);
                FUNCT_W'(FN_JR): begin
                    ctrl_o     = CTRL_W'(ALU_AND);
                    jump_sel_o = 1'b0;
                end
                default:           illegal_o = 1'b1;
            endcase
        end else begin
            case (alu_op_i)
                OP_W'(AOP_C1):  ctrl_o = CTRL_W'(ALU_C7);
                OP_W'(AOP_C2):  ctrl_o = CTRL_W'(ALU_SLT);
                OP_W'(AOP_C3):  ctrl_o = CTRL_W'(ALU_ADD);
                OP_W'(AOP_C4):  ctrl_o = CTRL_W'(ALU_C3);
                OP_W'(AOP_C5):  ctrl_o = CTRL_W'(ALU_OR);
                OP_W'(AOP_LUI): ctrl_o = CTRL_W'(ALU_LUI);
                OP_W'(AOP_C7):  ctrl_o = CTRL_W'(ALU_C12);
                default:        ctrl_o = CTRL_W'(ALU_AND);
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Registered, handshaked ALU control issue stage with multi-cycle mul sequencing.
// Define ALU_CTRL_ILLEGAL_TRAP_EN to report undefined R-type functs on illegal_o.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int FUNCT_W    = 6,
    parameter int OP_W       = 3,
    parameter int CTRL_W     = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [OP_W-1:0]    ALUOp_i,
    input  logic               flush_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [CTRL_W-1:0]  ALUCtrl_o,
    output logic               shamt_select_o,
    output logic               mux_jump_select_o,
    output logic               mul_busy_o,
    output logic               illegal_o
);

    localparam int                CNT_W     = $clog2(MUL_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(MUL_CYCLES - 1);
    localparam bit                MUL_MULTI = (MUL_CYCLES > 1);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam bit                TRAP_EN   = 1'b1;
`else
    localparam bit                TRAP_EN   = 1'b0;
`endif

    state_e             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               valid_r;
    logic [CTRL_W-1:0]  ctrl_r;
    logic               shamt_r;
    logic               jump_r;
    logic               busy_r;
    logic               illegal_r;

    logic [CTRL_W-1:0]  dec_ctrl_s;
    logic               dec_shamt_s;
    logic               dec_jump_s;
    logic               dec_is_mul_s;
    logic               dec_illegal_s;
    logic               accept_s;

    alu_op_decode #(
        .FUNCT_W (FUNCT_W),
        .OP_W    (OP_W),
        .CTRL_W  (CTRL_W)
    ) u_decode (
        .funct_i     (funct_i),
        .alu_op_i    (ALUOp_i),
        .ctrl_o      (dec_ctrl_s),
        .shamt_sel_o (dec_shamt_s),
        .jump_sel_o  (dec_jump_s),
        .is_mul_o    (dec_is_mul_s),
        .illegal_o   (dec_illegal_s)
    );

    assign ready_o  = (state_r == IDLE);
    assign accept_s = valid_i && ready_o && !flush_i;

    // Issue FSM, mul latency counter and registered execute-side outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            valid_r   <= 1'b0;
            ctrl_r    <= '0;
            shamt_r   <= 1'b0;
            jump_r    <= 1'b1;
            busy_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else if (flush_i) begin
            // Data outputs deliberately hold their last values across a flush
            state_r <= IDLE;
            cnt_r   <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        ctrl_r    <= dec_ctrl_s;
                        shamt_r   <= dec_shamt_s;
                        jump_r    <= dec_jump_s;
                        illegal_r <= dec_illegal_s & TRAP_EN;
                        if (dec_is_mul_s && MUL_MULTI) begin
                            state_r <= MUL;
                            cnt_r   <= CNT_LOAD;
                            valid_r <= 1'b0;
                            busy_r  <= 1'b1;
                        end else begin
                            valid_r <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                MUL: begin
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r - CNT_W'(1);
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign valid_o           = valid_r;
    assign ALUCtrl_o         = ctrl_r;
    assign shamt_select_o    = shamt_r;
    assign mux_jump_select_o = jump_r;
    assign mul_busy_o        = busy_r;
    assign illegal_o         = illegal_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed scoreboard bench for alu_issue_ctrl: a MUL_CYCLES=4 instance for the
// main sequence plus a MUL_CYCLES=1 instance for single-cycle multiply timing.
module tb_alu_issue_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, valid, flush;
    logic [5:0] funct;
    logic [2:0] op;
    logic       ready, vout, shamt, jsel, busy, ill;
    logic [3:0] ctrl;

    logic       v1, flush1;
    logic [5:0] f1;
    logic [2:0] o1;
    logic       ready1, vout1, shamt1, jsel1, busy1, ill1;
    logic [3:0] ctrl1;

    int errors = 0;
    int checks = 0;

    // expected record: {ctrl[3:0], shamt, jump, illegal}
    logic [6:0] q4[$];
    logic [6:0] q1[$];
    logic [6:0] e4, e1;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    alu_issue_ctrl #(.MUL_CYCLES(4)) u_dut4 (
        .clk_i (clk), .rst_i (rst), .valid_i (valid), .funct_i (funct),
        .ALUOp_i (op), .flush_i (flush), .ready_o (ready), .valid_o (vout),
        .ALUCtrl_o (ctrl), .shamt_select_o (shamt), .mux_jump_select_o (jsel),
        .mul_busy_o (busy), .illegal_o (ill)
    );

    alu_issue_ctrl #(.MUL_CYCLES(1)) u_dut1 (
        .clk_i (clk), .rst_i (rst), .valid_i (v1), .funct_i (f1),
        .ALUOp_i (o1), .flush_i (flush1), .ready_o (ready1), .valid_o (vout1),
        .ALUCtrl_o (ctrl1), .shamt_select_o (shamt1), .mux_jump_select_o (jsel1),
        .mul_busy_o (busy1), .illegal_o (ill1)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue4(input logic [2:0] o, input logic [5:0] f, input logic [6:0] e);
        valid = 1'b1;
        op    = o;
        funct = f;
        q4.push_back(e);
    endtask

    task automatic issue1(input logic [2:0] o, input logic [5:0] f, input logic [6:0] e);
        v1 = 1'b1;
        o1 = o;
        f1 = f;
        q1.push_back(e);
    endtask

    // Scoreboard: every valid_o pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (vout === 1'b1) begin
            if (q4.size() == 0) begin
                chk("dut4_unexpected_valid", 4'd1, 4'd0);
            end else begin
                e4 = q4.pop_front();
                chk("dut4_ctrl", ctrl, e4[6:3]);
                chk("dut4_shamt", 4'(shamt), 4'(e4[2]));
                chk("dut4_jump", 4'(jsel), 4'(e4[1]));
                chk("dut4_illegal", 4'(ill), 4'(e4[0]));
            end
        end
        if (vout1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_valid", 4'd1, 4'd0);
            end else begin
                e1 = q1.pop_front();
                chk("dut1_ctrl", ctrl1, e1[6:3]);
                chk("dut1_shamt", 4'(shamt1), 4'(e1[2]));
                chk("dut1_jump", 4'(jsel1), 4'(e1[1]));
            end
        end
    end

    logic [5:0] fn_tab[6]  = '{6'd3, 6'd7, 6'd34, 6'd36, 6'd37, 6'd42};
    logic [3:0] fn_exp[6]  = '{4'b1000, 4'b1001, 4'b0110, 4'b0000, 4'b0001, 4'b0100};
    logic [3:0] aop_exp[7] = '{4'b0111, 4'b0100, 4'b0010, 4'b0011, 4'b0001, 4'b1011, 4'b1100};

    initial begin
        rst = 1'b1; valid = 1'b1; funct = 6'd32; op = 3'd0; flush = 1'b0;
        v1 = 1'b0; f1 = 6'd0; o1 = 3'd0; flush1 = 1'b0;

        // reset held two cycles with valid offered
        step(); step();
        chk("rst_valid", 4'(vout), 4'd0);
        chk("rst_ctrl", ctrl, 4'b0000);
        chk("rst_shamt", 4'(shamt), 4'd0);
        chk("rst_jump", 4'(jsel), 4'd1);
        chk("rst_busy", 4'(busy), 4'd0);
        chk("rst_illegal", 4'(ill), 4'd0);
        chk("rst_ready", 4'(ready), 4'd1);
        chk("rst_valid1", 4'(vout1), 4'd0);
        rst = 1'b0; valid = 1'b0;
        step();
        chk("post_rst_valid", 4'(vout), 4'd0);

        // back-to-back add, jr, lui
        issue4(3'd0, 6'd32, {4'b0010, 1'b0, 1'b1, 1'b0});
        step();
        chk("b2b_ready0", 4'(ready), 4'd1);
        chk("b2b_valid0", 4'(vout), 4'd1);
        issue4(3'd0, 6'd8, {4'b0000, 1'b0, 1'b0, 1'b0});
        step();
        chk("b2b_ready1", 4'(ready), 4'd1);
        chk("b2b_valid1", 4'(vout), 4'd1);
        issue4(3'd6, 6'd0, {4'b1011, 1'b0, 1'b1, 1'b0});
        step();
        chk("b2b_valid2", 4'(vout), 4'd1);
        valid = 1'b0;
        step();
        chk("b2b_pulse_end", 4'(vout), 4'd0);

        // remaining R-type functs, back to back
        for (int i = 0; i < 6; i++) begin
            issue4(3'd0, fn_tab[i], {fn_exp[i], (i == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0});
            step();
        end
        // remaining ALUOp classes
        for (int i = 0; i < 7; i++) begin
            issue4(3'(i + 1), 6'd63, {aop_exp[i], 1'b0, 1'b1, 1'b0});
            step();
        end
        valid = 1'b0;
        step();

        // undefined funct
        issue4(3'd0, 6'd63, {4'b0000, 1'b0, 1'b1, ILL_EXP});
        step();
        chk("illegal_valid", 4'(vout), 4'd1);
        chk("illegal_flag", 4'(ill), 4'(ILL_EXP));
        valid = 1'b0;
        step();

        // multiply: accept at t, ready low t+1..t+3, valid at t+4
        issue4(3'd0, 6'd24, {4'b0101, 1'b0, 1'b1, 1'b0});
        step();
        valid = 1'b0;
        chk("mul_t1_ready", 4'(ready), 4'd0);
        chk("mul_t1_busy", 4'(busy), 4'd1);
        chk("mul_t1_valid", 4'(vout), 4'd0);
        step();
        chk("mul_t2_ready", 4'(ready), 4'd0);
        valid = 1'b1; op = 3'd0; funct = 6'd32;
        step();
        valid = 1'b0;
        chk("mul_t3_ready", 4'(ready), 4'd0);
        chk("mul_t3_valid", 4'(vout), 4'd0);
        chk("mul_t3_busy", 4'(busy), 4'd1);
        step();
        chk("mul_t4_valid", 4'(vout), 4'd1);
        chk("mul_t4_ctrl", ctrl, 4'b0101);
        chk("mul_t4_ready", 4'(ready), 4'd1);
        chk("mul_t4_busy", 4'(busy), 4'd0);
        step();
        chk("mul_t5_valid", 4'(vout), 4'd0);

        // flush mid-multiply at t+2
        valid = 1'b1; op = 3'd0; funct = 6'd24;
        step();
        valid = 1'b0;
        chk("fl_t1_busy", 4'(busy), 4'd1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_t3_ready", 4'(ready), 4'd1);
        chk("fl_t3_busy", 4'(busy), 4'd0);
        chk("fl_t3_valid", 4'(vout), 4'd0);
        chk("fl_t3_ctrl_held", ctrl, 4'b0101);
        step();
        chk("fl_t4_valid", 4'(vout), 4'd0);

        // flush beats valid in IDLE
        valid = 1'b1; op = 3'd0; funct = 6'd32; flush = 1'b1;
        step();
        valid = 1'b0; flush = 1'b0;
        chk("fl_prio_valid", 4'(vout), 4'd0);
        chk("fl_prio_ctrl_held", ctrl, 4'b0101);

        // reset abandons an in-flight multiply
        valid = 1'b1; op = 3'd0; funct = 6'd24;
        step();
        valid = 1'b0;
        chk("rmul_busy", 4'(busy), 4'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rmul_busy_clr", 4'(busy), 4'd0);
        chk("rmul_ready", 4'(ready), 4'd1);
        chk("rmul_ctrl", ctrl, 4'b0000);
        step(); step(); step();
        chk("rmul_no_valid", 4'(vout), 4'd0);

        // MUL_CYCLES = 1: mul issues with add timing
        issue1(3'd0, 6'd24, {4'b0101, 1'b0, 1'b1, 1'b0});
        step();
        chk("m1_valid", 4'(vout1), 4'd1);
        chk("m1_ready", 4'(ready1), 4'd1);
        chk("m1_busy", 4'(busy1), 4'd0);
        issue1(3'd0, 6'd24, {4'b0101, 1'b0, 1'b1, 1'b0});
        step();
        chk("m1_b2b_valid", 4'(vout1), 4'd1);
        chk("m1_b2b_ready", 4'(ready1), 4'd1);
        issue1(3'd0, 6'd34, {4'b0110, 1'b0, 1'b1, 1'b0});
        step();
        v1 = 1'b0;
        chk("m1_sub_valid", 4'(vout1), 4'd1);
        step();
        chk("m1_end_valid", 4'(vout1), 4'd0);

        step();
        chk("q4_drained", 4'(q4.size()), 4'd0);
        chk("q1_drained", 4'(q1.size()), 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Registered, handshaked successor to the single-cycle ALU controller for the pipelined CPU. It sits between decode and the execute stage. It decodes `ALUOp_i`/`funct_i` into the ALU operation code and the shamt and jump mux selects, and registers the result for execute. It also sequences multi-cycle multiplies, deasserting `ready_o` until the multiply's latency has elapsed.

## Interface

**Parameters**
- `MUL_CYCLES`, default 4: execute latency of `mul` in cycles; legal range ≥1.
- `FUNCT_W`, default 6: funct field width.
- `OP_W`, default 3: ALUOp width.
- `CTRL_W`, default 4: ALU operation code width.

**Ports** (clock and reset first)
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `valid_i` input 1: decode presents an operation.
- `funct_i` input `FUNCT_W`: R-type funct field.
- `ALUOp_i` input `OP_W`: main-control ALU class.
- `flush_i` input 1: squash the in-flight operation.
- `ready_o` output 1: an operation can be accepted this cycle.
- `valid_o` output 1: registered outputs are valid for execute.
- `ALUCtrl_o` output `CTRL_W`: ALU operation code.
- `shamt_select_o` output 1: select shamt as ALU operand A.
- `mux_jump_select_o` output 1: 0 selects the register target (`jr`), 1 selects normal.
- `mul_busy_o` output 1: multiply in progress.
- `illegal_o` output 1: undefined funct; see Configuration.

## Operation

**Accept rule**
- An operation is accepted when `valid_i && ready_o && !flush_i`.
- `ready_o` is combinational: it is 1 in `IDLE` and 0 in `MUL`.

**Decode for `ALUOp_i` = 0, by funct**
- 3 → 1000, `shamt_select_o` = 1.
- 7 → 1001.
- 24 → 0101 (`mul`).
- 32 → 0010.
- 34 → 0110.
- 36 → 0000.
- 37 → 0001.
- 42 → 0100.
- 8 (`jr`) → 0000, `mux_jump_select_o` = 0.
- Any other funct → 0000 (plus `illegal_o` when the macro is enabled).

**Decode for other `ALUOp_i` values**
- 1 → 0111.
- 2 → 0100.
- 3 → 0010.
- 4 → 0011.
- 5 → 0001.
- 6 → 1011.
- 7 → 1100.
- For all of these, `shamt_select_o` = 0 and `mux_jump_select_o` = 1.

**State machine** (states `IDLE`, `MUL`)
- `IDLE`, accept of a non-`mul` operation: register the decode and set `valid_o` = 1 next cycle. Stay in `IDLE`, so back-to-back issue is allowed.
- `IDLE`, accept of `mul` with `MUL_CYCLES` = 1: treated exactly like a non-`mul` operation.
- `IDLE`, accept of `mul` with `MUL_CYCLES` > 1:
  - register the decode (`ALUCtrl_o` = 0101);
  - load counter with `MUL_CYCLES`−1;
  - go to `MUL`;
  - set `valid_o` = 0 and `mul_busy_o` = 1.
- `MUL`: decrement the counter each cycle. At counter = 1, set `valid_o` = 1 next cycle, clear `mul_busy_o`, and return to `IDLE`. `ALUCtrl_o` is held throughout.
- `valid_o` is a one-cycle pulse per accepted operation. With no accept, it returns to 0.
- Counter width is `$clog2(MUL_CYCLES+1)`. The counter never wraps, because it is reloaded only on accept.

**Flush**
- `flush_i` has priority over `valid_i`.
- In any state, flush forces `IDLE`, `valid_o` = 0 next cycle, `mul_busy_o` = 0, and counter = 0.
- Data outputs keep their last values.

**Reset**
- `rst_i` has priority over everything else.
- Reset values: state `IDLE`, `ALUCtrl_o` = 0000, `shamt_select_o` = 0, `mux_jump_select_o` = 1, `valid_o` = 0, `mul_busy_o` = 0, `illegal_o` = 0, counter = 0.
- Reset mid-multiply abandons the multiply silently.
- Nothing is accepted in a cycle where `rst_i` = 1.

## Timing

- Non-`mul` latency: 1 cycle, accept edge to `valid_o`.
- `mul` latency: exactly `MUL_CYCLES` cycles, accept to `valid_o`.
- `ready_o` is low for `MUL_CYCLES`−1 cycles following a `mul` accept. The next operation can be accepted in the cycle `valid_o` is high.
- All outputs except `ready_o` are registered. `ready_o` depends only on state, not on inputs.

## Configuration

- `ALU_CTRL_ILLEGAL_TRAP_EN` defined:
  - an accepted R-type with undefined funct sets `illegal_o` = 1 alongside `valid_o`;
  - `ALUCtrl_o` = 0000.
- `ALU_CTRL_ILLEGAL_TRAP_EN` undefined:
  - `illegal_o` is tied to 0;
  - undefined funct decodes silently to 0000.

## Structure

- Shared package `alu_ctrl_pkg` holds:
  - funct constants (`FN_SRA`, `FN_SRAV`, `FN_MUL`, `FN_ADD`, `FN_SUB`, `FN_AND`, `FN_OR`, `FN_SLT`, `FN_JR`);
  - ALUOp constants;
  - ALU operation code constants;
  - the state enum.
- One sub-module, `alu_op_decode`: the pure combinational decode table. The top level holds the FSM, counter and output registers.

## Test plan

- Reset: `rst_i` = 1 for 2 cycles with `valid_i` = 1 → all outputs at reset values and nothing accepted.
- Back-to-back issue: add (op 0/32), then `jr` (0/8), then `lui` (op 6) on consecutive cycles → `ready_o` stays 1, and `valid_o` is high 3 consecutive cycles with:
  - `ALUCtrl_o` 0010, 0000, 1011;
  - `mux_jump_select_o` 1, 0, 1.
- Multiply with `MUL_CYCLES` = 4: `mul` accepted at cycle t → `ready_o` = 0 over t+1..t+3, `valid_o` = 1 only at t+4 with `ALUCtrl_o` = 0101, and a `valid_i` offered at t+2 is not accepted.
- Flush mid-multiply: flush at t+2 → `IDLE` at t+3, `ready_o` = 1, no `valid_o` pulse, `mul_busy_o` = 0.
- Illegal funct: funct 63, with the macro on and then off → `illegal_o` = 1 with `valid_o` when on, and 0 when off.
- `MUL_CYCLES` = 1 build: `mul` behaves like add timing, with `valid_o` after 1 cycle and `ready_o` never low.
